// File: rtl/pipeline_id_hazard.sv
// Instruction-decode stage: register file with MEM/WB bypass, load-use and branch hazard
// detection, early branch/jump resolution, and the ID/EX pipeline register.
module pipeline_id_hazard #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [DATA_W-1:0] if_pc,
   input  logic [31:0]       if_instr,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              ctrl_regwr,
   input  logic              ctrl_memrd,
   input  logic              flush,
   input  logic              ex_hold,
   input  logic              mem_regwr,
   input  logic              mem_memrd,
   input  logic [4:0]        mem_dst,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_regwr,
   input  logic [4:0]        wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              redirect,
   output logic [DATA_W-1:0] redirect_pc,
   output logic              ex_valid,
   output logic              ex_regwr,
   output logic              ex_memrd,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [15:0]       ex_imm,
   output logic [4:0]        ex_shamt,
   output logic [4:0]        ex_dst,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       stall_count
);
   typedef struct packed {
      logic              valid;
      logic              regwr;
      logic              memrd;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [15:0]       imm;
      logic [4:0]        shamt;
      logic [4:0]        dst;
      logic [CTRL_W-1:0] ctrl;
   } idex_t;

   idex_t             idex_q, idex_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   logic [DATA_W-1:0] regs_q [32];
   logic [DATA_W-1:0] regs_d [32];

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd, dst_dec;
   assign op    = if_instr[31:26];
   assign rs    = if_instr[25:21];
   assign rt    = if_instr[20:16];
   assign rd    = if_instr[15:11];
   assign funct = if_instr[5:0];

   // Register 0 and any index at or above NREG are constant zero
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rf
         if (gi == 0 || gi >= NREG) begin : g_zero
            assign regs_d[gi] = '0;
         end else begin : g_reg
            assign regs_d[gi] = (wb_regwr && wb_dst == 5'(gi)) ? wb_data : regs_q[gi];
         end
      end
   endgenerate

   logic              mem_fwd, wb_fwd;
   logic [DATA_W-1:0] op_a, op_b;
   assign mem_fwd = mem_regwr && !mem_memrd && (mem_dst != 5'd0);
   assign wb_fwd  = wb_regwr && (wb_dst != 5'd0);
   assign op_a = (mem_fwd && mem_dst == rs) ? mem_data :
                 (wb_fwd && wb_dst == rs)   ? wb_data  : regs_q[rs];
   assign op_b = (mem_fwd && mem_dst == rt) ? mem_data :
                 (wb_fwd && wb_dst == rt)   ? wb_data  : regs_q[rt];

   logic rs_used, rt_used, is_branch, is_jr, is_j, br_dep, hz_rs, hz_rt, hz;
   assign rs_used   = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
   assign rt_used   = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
   assign is_branch = (op == 6'h01) || (op >= 6'h04 && op <= 6'h07);
   assign is_jr     = (op == 6'h00) && (funct == 6'h08 || funct == 6'h09);
   assign is_j      = (op == 6'h02) || (op == 6'h03);
   assign br_dep    = is_branch || is_jr;

   // Branches resolve here, so they also wait on ALU results in EX and loads in MEM
   assign hz_rs = rs_used && (rs != 5'd0) &&
                  ((idex_q.valid && idex_q.memrd && idex_q.dst == rs) ||
                   (br_dep && ((idex_q.valid && idex_q.regwr && idex_q.dst == rs) ||
                               (mem_memrd && mem_dst == rs))));
   assign hz_rt = rt_used && (rt != 5'd0) &&
                  ((idex_q.valid && idex_q.memrd && idex_q.dst == rt) ||
                   (br_dep && ((idex_q.valid && idex_q.regwr && idex_q.dst == rt) ||
                               (mem_memrd && mem_dst == rt))));
   assign hz    = hz_rs || hz_rt;
   assign stall = if_valid && !flush && (hz || ex_hold);

   logic              br_taken;
   logic [DATA_W-1:0] br_target;
   always_comb begin
      br_taken = 1'b0;
      case (op)
         6'h01:   br_taken = op_a[DATA_W-1];
         6'h04:   br_taken = (op_a == op_b);
         6'h05:   br_taken = (op_a != op_b);
         6'h06:   br_taken = op_a[DATA_W-1] || (op_a == '0);
         6'h07:   br_taken = !op_a[DATA_W-1] && (op_a != '0);
         default: br_taken = 1'b0;
      endcase
   end

   assign br_target = if_pc + {{(DATA_W-18){if_instr[15]}}, if_instr[15:0], 2'b00};
   assign redirect  = if_valid && !stall && !flush && (br_taken || is_j || is_jr);
   assign redirect_pc = is_jr ? op_a :
                        is_j  ? {if_pc[DATA_W-1:28], if_instr[25:0], 2'b00} : br_target;

   assign dst_dec = (op == 6'h03) ? 5'd31 : (op == 6'h00) ? rd : rt;

   always_comb begin
      idex_d = idex_q;
      if (flush || (!ex_hold && (hz || !if_valid))) begin
         idex_d = '0;
      end else if (!ex_hold) begin
         idex_d.valid = 1'b1;
         idex_d.regwr = ctrl_regwr && (if_instr != 32'd0);
         idex_d.memrd = ctrl_memrd;
         idex_d.pc    = if_pc;
         idex_d.a     = op_a;
         idex_d.b     = op_b;
         idex_d.imm   = if_instr[15:0];
         idex_d.shamt = if_instr[10:6];
         idex_d.dst   = dst_dec;
         idex_d.ctrl  = ctrl_in;
      end
      stall_cnt_d = (stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q      <= '0;
         stall_cnt_q <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         idex_q      <= idex_d;
         stall_cnt_q <= stall_cnt_d;
         regs_q      <= regs_d;
      end
   end

   assign ex_valid    = idex_q.valid;
   assign ex_regwr    = idex_q.regwr;
   assign ex_memrd    = idex_q.memrd;
   assign ex_pc       = idex_q.pc;
   assign ex_a        = idex_q.a;
   assign ex_b        = idex_q.b;
   assign ex_imm      = idex_q.imm;
   assign ex_shamt    = idex_q.shamt;
   assign ex_dst      = idex_q.dst;
   assign ex_ctrl     = idex_q.ctrl;
   assign stall_count = stall_cnt_q;
endmodule
